// File: rtl/div3_pkg.sv
// Shared types and helpers for the divisible-by-3 sharing controller.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

    // Index width that stays at least one bit even for tiny requester counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div3_share_ctrl_if.sv
// Request/response bundle between the requesters, the controller and the response consumer.
interface div3_share_ctrl_if
    import div3_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) ();
    localparam int ID_W = clog2_min1(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_div;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data, resp_div
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data, resp_div
    );
endinterface

// File: rtl/check_divisibility.sv
// Combinational divisible-by-3 checker for an unsigned operand.
module check_divisibility #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_div
);
    assign o_div = ((i_data % DATA_W'(3)) == '0);
endmodule

// File: rtl/div3_share_ctrl_rr_pick.sv
// Round-robin one-hot selector: first set request at or above the pointer, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx
);
    int w_k;

    // Scan from the farthest offset down so the closest hit to the pointer wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_k     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_k = (int'(i_ptr) + i) % N_REQ;
            if (i_req[w_k]) begin
                o_grant      = '0;
                o_grant[w_k] = 1'b1;
                o_idx        = ID_W'(w_k);
            end
        end
    end
endmodule

// File: rtl/div3_share_ctrl.sv
// Round-robin sharing of one divisible-by-3 checker among N_REQ requesters, with saturating stats.
//   state | meaning
//   IDLE  | offer grant to next requester in rotation
//   EVAL  | latched operand drives the shared checker
//   RESP  | response held until the consumer takes it
module div3_share_ctrl
    import div3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    div3_share_ctrl_if.slave    bus,
    input  logic                stat_clr,
    output logic [CNT_W-1:0]    stat_total,
    output logic [CNT_W-1:0]    stat_div
);
    localparam int ID_W = clog2_min1(N_REQ);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EVAL = EVAL;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_op;
    logic              r_resp_valid;
    logic [ID_W-1:0]   r_resp_id;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_div;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_div;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_gidx;
    logic [DATA_W-1:0] w_req_op;
    logic              w_is_div;
    logic              w_accept;
    logic              w_done;
    logic [ID_W-1:0]   w_next_ptr;

    rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    check_divisibility #(.DATA_W(DATA_W)) u_chk (
        .i_data (r_op),
        .o_div  (w_is_div)
    );

    assign w_req_op   = bus.req_data[w_gidx*DATA_W +: DATA_W];
    assign w_accept   = (r_state == ST_IDLE) && (|bus.req_valid);
    assign w_done     = (r_state == ST_RESP) && bus.resp_ready;
    assign w_next_ptr = (r_resp_id == ID_W'(N_REQ - 1)) ? '0 : r_resp_id + 1'b1;

    assign bus.req_ready  = ((r_state == ST_IDLE) && !rst) ? w_grant : '0;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_div   = r_resp_div;
    assign stat_total     = r_total;
    assign stat_div       = r_div;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_op         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_div   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_req_op;
                        r_id    <= w_gidx;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    r_resp_div   <= w_is_div;
                    r_resp_data  <= r_op;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_done) begin
                        r_resp_valid <= 1'b0;
                        r_ptr        <= w_next_ptr;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Clear takes priority over a coinciding completion.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_total <= '0;
            r_div   <= '0;
        end else if (w_done) begin
            if (r_total != '1)
                r_total <= r_total + 1'b1;
            if (r_resp_div && (r_div != '1))
                r_div <= r_div + 1'b1;
        end
    end
endmodule

// File: doc/div3_share_ctrl.md
Name: div3_share_ctrl

Overview:
- Shares one combinational divisible-by-3 checker (`check_divisibility`, DATA_W-wide) between N_REQ requesters using round-robin arbitration.
- Each request is a valid/ready transfer of one operand. The controller latches the operand, evaluates it on the shared checker, and returns the verdict with the requester ID on a single response channel that supports backpressure.
- Keeps saturating statistics counters for software readout.
- Sits between the packet-classification requesters and the shared arithmetic resource.

Parameters:
- DATA_W, 8, operand width in bits; must be ≥2.
- N_REQ, 4, number of requesters; must be ≥2.
- CNT_W, 16, width of each statistics counter.
- ID_W, derived as max(1, clog2(N_REQ)), requester index width; localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*DATA_W  flattened operands; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant/accept; at most one bit set per cycle.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester being answered.
- resp_data  out  DATA_W  echoed operand.
- resp_div  out  1  1 when resp_data mod 3 == 0.
- stat_clr  in  1  synchronous clear of both counters.
- stat_total  out  CNT_W  number of completed responses, saturating.
- stat_div  out  CNT_W  number of completed responses with resp_div=1, saturating.

Behaviour:
- Reset:
  - rst=1 at a clock edge forces state IDLE and round-robin pointer to 0.
  - resp_valid, resp_id, resp_data, resp_div, stat_total and stat_div all reset to 0.
  - req_ready is 0 while rst=1.
  - A reset in any state drops the in-flight transaction; no response is emitted for it.
- FSM states are IDLE, EVAL and RESP.
- IDLE:
  - If any req_valid bit is set, grant the first set bit at or after the pointer, searching upward with wrap from N_REQ-1 to 0.
  - req_ready[g] is asserted combinationally in the same cycle; a transfer occurs when req_valid[g] & req_ready[g].
  - On the transfer edge: latch req_data[g] into the operand register, latch g into the ID register, and go to EVAL.
  - If no req_valid bit is set, stay in IDLE with req_ready all 0.
- EVAL:
  - The operand register drives the shared checker.
  - On the edge: capture the checker output into resp_div, copy the operand into resp_data and the ID into resp_id, set resp_valid=1, and go to RESP.
  - req_ready is all 0.
- RESP:
  - Hold resp_valid, resp_id, resp_data and resp_div stable until resp_valid & resp_ready.
  - On that edge: clear resp_valid, set pointer = (resp_id+1) mod N_REQ, increment the counters, and return to IDLE.
  - req_ready is all 0.
- Timing:
  - Latency is 2 cycles from the accept edge to resp_valid high.
  - Minimum spacing is 3 cycles per transaction (no overlap).
- Fairness:
  - The pointer advances only on response completion, so continuously requesting ports are served in strict rotation.
  - Requesters must hold req_valid and req_data stable until accepted; the controller does not rely on this for correctness.
- Counters:
  - On completion: stat_total += 1, and stat_div += 1 if resp_div=1.
  - Each counter saturates at 2^CNT_W-1.
  - stat_clr=1 zeroes both counters. If stat_clr coincides with a completion, the clear wins and the completion is not counted.
- Arithmetic: operands are unsigned, so operand 0 is divisible (resp_div=1).

Decomposition:
- Package div3_pkg:
  - State enum {IDLE, EVAL, RESP}.
  - Function clog2_min1 used to derive ID_W.
- Sub-module rr_pick:
  - Combinational round-robin one-hot selector.
  - Inputs: request vector, pointer. Outputs: one-hot grant, encoded index.
- The existing `check_divisibility` checker is instantiated once; it is not modified.

Test Plan:
- Single request: reset, then req_valid=0001 with operand 21 → req_ready=0001 in the same cycle; 2 cycles later resp_valid=1, resp_id=0, resp_data=21, resp_div=1.
- Operand sweep on port 2: operands 0, 128, 255, 7 → resp_div = 1, 0, 1, 0 respectively; at the end stat_total=4, stat_div=2.
- Fairness: all four ports held valid from reset → resp_id sequence 0,1,2,3,0,1; only one req_ready bit ever set.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → response fields stable; no new req_ready; on release, transaction completes and pointer advances.
- Reset mid-operation: assert rst in EVAL → next cycle resp_valid=0, pointer 0, counters 0; the next request from port 3 is answered with resp_id=3.
- Counter saturation and clear: CNT_W=2, 5 divisible operands → stat_total=3, stat_div=3; stat_clr on a completion edge → both 0.
